// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode front end.
//   NOP_INSTR   : canonical RV32I NOP (addi x0, x0, 0) presented when no
//                 instruction is available.
//   fetch_pkt_t : one fetched instruction together with its PC.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage : core_pkg

// File: rtl/instr_queue.sv
// instr_queue: decoupling FIFO between fetch and decode.
// Buffers up to DEPTH {instr, pc} pairs with first-word fall-through head
// outputs. A taken branch from execute (e_b_taken) empties the queue.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous active-low reset
//   f_valid   : fetch presents a valid instr/pc pair
//   f_instr   : instruction word from fetch
//   f_pc      : PC of f_instr
//   f_ready   : queue can accept a push (not full); fetch PC enable
//   e_b_taken : flush request from execute
//   d_ready   : decode consumes the head entry
//   d_valid   : head entry is valid (not empty)
//   d_instr   : head instruction, NOP when empty
//   d_pc      : head PC, 0 when empty
//   count     : current occupancy, 0..DEPTH
module instr_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_valid,
  input  logic [31:0]      f_instr,
  input  logic [31:0]      f_pc,
  output logic             f_ready,
  input  logic             e_b_taken,
  input  logic             d_ready,
  output logic             d_valid,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_pkt_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // All outputs derive from registered state only; there is no bypass from
  // f_* to d_*, so an empty queue always shows the NOP/0 head.
  assign f_ready = (cnt != CNT_W'(DEPTH));
  assign d_valid = (cnt != '0);
  assign count   = cnt;
  assign d_instr = d_valid ? mem[rd_ptr].instr : NOP_INSTR;
  assign d_pc    = d_valid ? mem[rd_ptr].pc    : 32'h0;

  // A flush discards any push or pop requested in the same cycle.
  assign push = f_valid && f_ready && !e_b_taken;
  assign pop  = d_valid && d_ready && !e_b_taken;

  // Pointers and occupancy. Pointers are exactly PTR_W bits wide, so the
  // increment from DEPTH-1 wraps to 0 naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (e_b_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is cleared on reset so stale contents never reappear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{instr: f_instr, pc: f_pc};
    end
  end

endmodule : instr_queue

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             f_valid;
  logic [31:0]      f_instr;
  logic [31:0]      f_pc;
  logic             f_ready;
  logic             e_b_taken;
  logic             d_ready;
  logic             d_valid;
  logic [31:0]      d_instr;
  logic [31:0]      d_pc;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of {instr, pc}, front is the head.
  logic [63:0] q[$];

  instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_instr(f_instr),
    .f_pc(f_pc), .f_ready(f_ready), .e_b_taken(e_b_taken),
    .d_ready(d_ready), .d_valid(d_valid), .d_instr(d_instr),
    .d_pc(d_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic check_model();
    logic [31:0] e_instr, e_pc;
    e_instr = (q.size() != 0) ? q[0][63:32] : 32'h00000013;
    e_pc    = (q.size() != 0) ? q[0][31:0]  : 32'h0;
    chk("count",   32'(count),   32'(q.size()));
    chk("f_ready", 32'(f_ready), 32'(q.size() != DEPTH));
    chk("d_valid", 32'(d_valid), 32'(q.size() != 0));
    chk("d_instr", d_instr, e_instr);
    chk("d_pc",    d_pc,    e_pc);
  endtask

  // Drive one cycle of inputs (from a negedge), advance the model across the
  // rising edge, then check on the following negedge.
  task automatic step(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit dr, input bit fl);
    bit do_push, do_pop;
    f_valid = fv; f_instr = ins; f_pc = pc; d_ready = dr; e_b_taken = fl;
    do_push = fv && (q.size() < DEPTH) && !fl;
    do_pop  = dr && (q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({ins, pc});
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    logic [31:0] last_pc;
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_in = '{32'h11, 32'h22, 32'h33};

    reset = 1'b0; f_valid = 0; f_instr = 0; f_pc = 0; d_ready = 0; e_b_taken = 0;
    #12;
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_instr", d_instr, 32'h00000013);
    chk("rst_d_pc",    d_pc,    32'h0);
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_f_ready", 32'(f_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);

    // Three pushes with decode stalled, then three pops.
    for (int i = 0; i < 3; i++) begin
      step(1, exp_in[i], exp_pc[i], 0, 0);
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      chk("pop_instr", d_instr, exp_in[i]);
      chk("pop_pc",    d_pc,    exp_pc[i]);
      step(0, 0, 0, 1, 0);
    end
    chk("drained_count", 32'(count), 32'd0);

    // Fill to DEPTH, try one more push, then a single pop.
    for (int i = 0; i < DEPTH; i++) step(1, 32'hA0 + 32'(i), 32'h10 + 32'(4 * i), 0, 0);
    chk("full_f_ready", 32'(f_ready), 32'd0);
    chk("full_count",   32'(count),   32'd4);
    step(1, 32'hDEAD, 32'h99, 0, 0);
    chk("full_ignored_head", d_pc, 32'h10);
    chk("full_ignored_count", 32'(count), 32'd4);
    step(0, 0, 0, 1, 0);
    chk("after_pop_f_ready", 32'(f_ready), 32'd1);
    chk("after_pop_head", d_pc, 32'h14);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

    // Wrap: one entry preloaded, then push+pop every cycle.
    step(1, 32'h1000, 32'h100, 0, 0);
    last_pc = d_pc;
    for (int k = 1; k <= 10; k++) begin
      step(1, 32'h1000 + 32'(k), 32'h100 + 32'(4 * k), 1, 0);
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_pc_step", d_pc, last_pc + 32'd4);
      last_pc = d_pc;
    end
    step(0, 0, 0, 1, 0);

    // Flush with 3 entries queued while push and pop are also requested.
    for (int i = 0; i < 3; i++) step(1, 32'hB0 + 32'(i), 32'h300 + 32'(4 * i), 0, 0);
    step(1, 32'hBEEF, 32'h400, 1, 1);
    chk("flush_count",   32'(count),   32'd0);
    chk("flush_d_valid", 32'(d_valid), 32'd0);
    step(1, 32'hC0, 32'h200, 0, 0);
    chk("post_flush_head", d_pc, 32'h200);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle with two entries queued.
    step(1, 32'hD0, 32'h500, 0, 0);
    step(1, 32'hD1, 32'h504, 0, 0);
    f_valid = 0; d_ready = 0; e_b_taken = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_count",   32'(count),   32'd0);
    chk("async_d_valid", 32'(d_valid), 32'd0);
    chk("async_d_instr", d_instr, 32'h00000013);
    chk("async_f_ready", 32'(f_ready), 32'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1, 32'hE0, 32'h600, 0, 0);
    chk("after_reset_head", d_pc, 32'h600);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 2000; n++) begin
      step(bit'($urandom_range(0, 3) != 0), $urandom, $urandom,
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_queue

// File: doc/instr_queue.md
# instr_queue

Decoupling FIFO between the fetch stage and the decode stage. It buffers up to DEPTH {instr, pc} pairs so decode can stall without stalling instruction memory addressing. A taken branch from execute flushes it. Fetch uses the f_ready output as its PC enable.

## Interface
Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- f_valid  input  1  fetch presents a valid instr/pc pair this cycle.
- f_instr  input  32  instruction word from fetch.
- f_pc  input  32  PC of f_instr.
- f_ready  output  1  queue can accept a push; equals !full.
- e_b_taken  input  1  flush request from execute (taken branch/jump).
- d_ready  input  1  decode consumes the head entry this cycle.
- d_valid  output  1  head entry is valid; equals !empty.
- d_instr  output  32  head instruction; 32'h00000013 (NOP) when empty.
- d_pc  output  32  head PC; 32'h0 when empty.
- count  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- State:
  - DEPTH-entry storage of {instr, pc}.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter cnt.
- Push: f_valid && f_ready && !e_b_taken. Writes the entry at wr_ptr, then wr_ptr increments.
- Pop: d_valid && d_ready && !e_b_taken. rd_ptr increments.
- Push and pop in the same cycle: both occur, cnt unchanged. Only possible when 0 < cnt < DEPTH.
- Push while full: cannot occur, since f_ready = 0. A push attempted with f_ready = 0 is ignored and storage is untouched.
- Pop while empty: ignored; pointers and cnt unchanged.
- Flush (e_b_taken = 1):
  - At the next edge, wr_ptr = rd_ptr = 0 and cnt = 0.
  - A push or pop requested in the same cycle is discarded.
  - Flush has priority over everything except reset.
- Head outputs are read combinationally from the entry at rd_ptr (first-word fall-through). They are forced to NOP / 0 when cnt == 0.
- count = cnt.
- f_ready = (cnt != DEPTH).
- d_valid = (cnt != 0).

## Timing
- Reset (reset = 0, asynchronous):
  - wr_ptr = rd_ptr = cnt = 0 and all storage = 0, immediately.
  - Outputs: f_ready = 1, d_valid = 0, d_instr = 32'h00000013, d_pc = 0, count = 0.
- Reset released mid-operation: all prior contents are lost. The first push after deassertion lands in entry 0.
- Latency: an entry pushed at edge N is visible on d_* with d_valid = 1 after edge N. There is no same-cycle bypass, so an empty queue never presents f_* directly.
- Full: after the DEPTH-th push without a pop, f_ready drops in the following cycle. It rises again in the cycle after the first pop.
- Pointer wrap: an increment from DEPTH-1 goes to 0. Ordering is preserved across the wrap.
- Flush while full or while empty: same result, cnt = 0 after the edge; f_ready = 1 and d_valid = 0 in the next cycle.
- All outputs are glitch-relevant only at clock edges; there are no combinational paths from f_* to d_*.
- Combinational paths from inputs to outputs: none. f_ready, d_valid, d_instr, d_pc and count depend on state only.

## Structure
- Shared package (core_pkg) holds:
  - NOP_INSTR = 32'h00000013.
  - typedef fetch_pkt_t = struct packed {logic [31:0] instr; logic [31:0] pc;}.
- Storage is an array of fetch_pkt_t indexed by the pointers.
- No sub-module: pointers, counter and storage are simple enough to live inline.

## Test plan
- Reset, then idle: d_valid = 0, d_instr = 32'h00000013, d_pc = 0, count = 0, f_ready = 1.
- Push pc = 0x00, 0x04, 0x08 with instr = 0x11, 0x22, 0x33 while d_ready = 0; then d_ready = 1 for 3 cycles:
  - count goes 1, 2, 3.
  - Pops return 0x11/0x00, 0x22/0x04, 0x33/0x08 in order.
  - count returns to 0.
- Fill DEPTH = 4 entries (pc 0x10..0x1C):
  - f_ready = 0 and count = 4.
  - A further f_valid is ignored; head stays pc 0x10.
  - One pop gives f_ready = 1 on the next cycle.
- Wrap: alternate push and pop for 10 cycles with continuous f_valid and d_ready (pc 0x100 + 4k). d_pc sequence is monotonic with no loss and count stays at 1.
- Flush with 3 entries queued while f_valid = 1 and d_ready = 1 in the same cycle:
  - Next cycle count = 0 and d_valid = 0.
  - The following push of pc 0x200 appears as head one cycle later.
- Assert reset = 0 asynchronously mid-cycle with 2 entries queued: outputs return to reset values before the next clk edge.
